// File: rtl/associative_memory_trainer.sv
// Trainer for the associative memory: fuses labelled three-modality samples by bitwise majority,
// accumulates per-class bit counts one chunk per cycle, then streams thresholded class prototypes.
module associative_memory_trainer #(
  parameter int HV_DIMENSION = 2000,
  parameter int CHUNK        = 250,
  parameter int CLASSES      = 2,
  parameter int LABEL_WIDTH  = 1,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic                    Finalize_SI,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_mod1_DI,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_mod2_DI,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_mod3_DI,
  input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] PrototypeOut_DO,
  output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
  output logic [CNT_WIDTH-1:0]    SampleCountOut_DO
);

  localparam int NCHUNK = HV_DIMENSION / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0]          LAST_CHUNK = CW'(NCHUNK - 1);
  localparam logic [LABEL_WIDTH-1:0] LAST_CLASS = LABEL_WIDTH'(CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    CLEAR = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [0:HV_DIMENSION-1] fused_q, fused_d;
  logic [LABEL_WIDTH-1:0]  label_q, label_d;
  logic [LABEL_WIDTH-1:0]  idx_q, idx_d;
  logic [CW-1:0]           chunk_q, chunk_d;
  logic [CNT_WIDTH-1:0]    samples_q [CLASSES];
  logic [CNT_WIDTH-1:0]    samples_d [CLASSES];
  logic [CNT_WIDTH-1:0]    count_q   [CLASSES][HV_DIMENSION];
  logic [CNT_WIDTH-1:0]    count_d   [CLASSES][HV_DIMENSION];
  logic                    sat_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Saturated sample counter for the latched label; out-of-range labels match no class.
  always_comb begin
    sat_s = 1'b0;
    for (int j = 0; j < CLASSES; j++) begin
      sat_s = sat_s | ((label_q == LABEL_WIDTH'(j)) && (samples_q[j] == {CNT_WIDTH{1'b1}}));
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d   = state_q;
    fused_d   = fused_q;
    label_d   = label_q;
    idx_d     = idx_q;
    chunk_d   = chunk_q;
    samples_d = samples_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (Finalize_SI) begin
          idx_d   = '0;
          state_d = EMIT;
        end else if (ValidIn_SI) begin
          for (int k = 0; k < HV_DIMENSION; k++) begin
            fused_d[k] = maj3(HypervectorIn_mod1_DI[k], HypervectorIn_mod2_DI[k],
                              HypervectorIn_mod3_DI[k]);
          end
          label_d = LabelIn_DI;
          chunk_d = '0;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        for (int j = 0; j < CLASSES; j++) begin
          for (int k = 0; k < HV_DIMENSION; k++) begin
            count_d[j][k] = count_q[j][k] + CNT_WIDTH'((label_q == LABEL_WIDTH'(j)) &&
                            (CW'(k / CHUNK) == chunk_q) && !sat_s && fused_q[k]);
          end
          samples_d[j] = samples_q[j] + CNT_WIDTH'((label_q == LABEL_WIDTH'(j)) &&
                         (chunk_q == LAST_CHUNK) && !sat_s);
        end
        if (chunk_q == LAST_CHUNK) begin
          state_d = IDLE;
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end
      EMIT: begin
        if (ReadyIn_SI) begin
          if (idx_q == LAST_CLASS) begin
            idx_d   = '0;
            state_d = CLEAR;
          end else begin
            idx_d = idx_q + LABEL_WIDTH'(1);
          end
        end else begin
          state_d = EMIT;
        end
      end
      CLEAR: begin
        for (int j = 0; j < CLASSES; j++) begin
          samples_d[j] = '0;
          for (int k = 0; k < HV_DIMENSION; k++) begin
            count_d[j][k] = '0;
          end
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q <= IDLE;
      fused_q <= '0;
      label_q <= '0;
      idx_q   <= '0;
      chunk_q <= '0;
      for (int j = 0; j < CLASSES; j++) begin
        samples_q[j] <= '0;
        for (int k = 0; k < HV_DIMENSION; k++) begin
          count_q[j][k] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      fused_q   <= fused_d;
      label_q   <= label_d;
      idx_q     <= idx_d;
      chunk_q   <= chunk_d;
      samples_q <= samples_d;
      count_q   <= count_d;
    end
  end

  // Output decode; counts are compared one bit wider so 2*count cannot wrap.
  always_comb begin
    ReadyOut_SO       = (state_q == IDLE) && !Finalize_SI;
    ValidOut_SO       = (state_q == EMIT);
    LabelOut_DO       = (state_q == EMIT) ? idx_q : '0;
    SampleCountOut_DO = '0;
    PrototypeOut_DO   = '0;
    for (int j = 0; j < CLASSES; j++) begin
      logic sel;
      sel = (state_q == EMIT) && (idx_q == LABEL_WIDTH'(j));
      SampleCountOut_DO = SampleCountOut_DO | (sel ? samples_q[j] : '0);
      for (int k = 0; k < HV_DIMENSION; k++) begin
        PrototypeOut_DO[k] = PrototypeOut_DO[k] |
                             (sel && ({count_q[j][k], 1'b0} > {1'b0, samples_q[j]}));
      end
    end
  end

endmodule

// File: tb/tb_associative_memory_trainer.sv
// Directed bench for associative_memory_trainer with a 16-bit, 4-chunk, 2-class, 2-bit-count build.
module tb_associative_memory_trainer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        finalize = 1'b0;
  logic [0:15] hv1 = '0;
  logic [0:15] hv2 = '0;
  logic [0:15] hv3 = '0;
  logic        label_in = 1'b0;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [0:15] proto;
  logic        label_out;
  logic [1:0]  cnt_out;

  int n_vec  = 0;
  int n_fail = 0;

  associative_memory_trainer #(
    .HV_DIMENSION(16), .CHUNK(4), .CLASSES(2), .LABEL_WIDTH(1), .CNT_WIDTH(2)
  ) dut (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(valid_in), .ReadyOut_SO(ready_out),
    .Finalize_SI(finalize), .HypervectorIn_mod1_DI(hv1), .HypervectorIn_mod2_DI(hv2),
    .HypervectorIn_mod3_DI(hv3), .LabelIn_DI(label_in), .ValidOut_SO(valid_out),
    .ReadyIn_SI(ready_in), .PrototypeOut_DO(proto), .LabelOut_DO(label_out),
    .SampleCountOut_DO(cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fin;
    logic [15:0] m1, m2, m3;
    logic        lbl;
    logic [15:0] p0;
    logic [1:0]  c0;
    logic [15:0] p1;
    logic [1:0]  c1;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_sample(input string tag, input logic [15:0] m1, input logic [15:0] m2,
                           input logic [15:0] m3, input logic lbl);
    int n;
    valid_in = 1'b1;
    hv1 = m1; hv2 = m2; hv3 = m3; label_in = lbl;
    #1;
    chk({tag, "_ready_idle"}, 32'(ready_out), 32'd1);
    tick;
    valid_in = 1'b0;
    n = 0;
    while (ready_out == 1'b0 && n < 10) begin
      n++;
      tick;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd4);
  endtask

  task automatic chk_emit(input string tag, input logic lbl, input logic [15:0] p,
                          input logic [1:0] c);
    chk({tag, "_valid"}, 32'(valid_out), 32'd1);
    chk({tag, "_label"}, 32'(label_out), 32'(lbl));
    chk({tag, "_proto"}, 32'(proto), 32'(p));
    chk({tag, "_count"}, 32'(cnt_out), 32'(c));
  endtask

  task automatic do_finalize(input string tag, input logic [15:0] p0, input logic [1:0] c0,
                             input logic [15:0] p1, input logic [1:0] c1, input bit with_valid);
    finalize = 1'b1;
    ready_in = 1'b1;
    valid_in = with_valid;
    hv1 = 16'hFFFF; hv2 = 16'hFFFF; hv3 = 16'hFFFF; label_in = 1'b0;
    #1;
    chk({tag, "_ready_lo"}, 32'(ready_out), 32'd0);
    tick;
    finalize = 1'b0;
    valid_in = 1'b0;
    chk_emit({tag, "_c0"}, 1'b0, p0, c0);
    tick;
    chk_emit({tag, "_c1"}, 1'b1, p1, c1);
    tick;
    chk({tag, "_clear_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_clear_ready"}, 32'(ready_out), 32'd0);
    tick;
    chk({tag, "_idle_ready"}, 32'(ready_out), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready_out), 32'd1);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_proto"}, 32'(proto), 32'd0);
    chk({tag, "_label"}, 32'(label_out), 32'd0);
    chk({tag, "_count"}, 32'(cnt_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[1]  = '{1'b0, 16'h00FF, 16'h00FF, 16'h00FF, 1'b0, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[2]  = '{1'b0, 16'h000F, 16'h000F, 16'h000F, 1'b0, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[3]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h00FF, 2'd3, 16'h0000, 2'd0};
    tbl[4]  = '{1'b0, 16'hFF00, 16'h0FF0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[6]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd2, 16'h0000, 2'd0};
    tbl[7]  = '{1'b0, 16'hF0F0, 16'h3C3C, 16'h0FF0, 1'b1, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[8]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h3CF0, 2'd1};
    tbl[9]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[10] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[11] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[12] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 2'd0, 16'h0000, 2'd0};
    tbl[13] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'hFFFF, 2'd3};

    #1 rst = 1'b1;
    #2;
    chk_reset_outputs("reset");
    tick;
    tick;
    #3 rst = 1'b0;
    tick;

    for (int r = 0; r < 14; r++) begin
      if (tbl[r].fin) begin
        do_finalize($sformatf("row%0d", r), tbl[r].p0, tbl[r].c0, tbl[r].p1, tbl[r].c1, 1'b0);
      end else begin
        do_sample($sformatf("row%0d", r), tbl[r].m1, tbl[r].m2, tbl[r].m3, tbl[r].lbl);
      end
    end

    // Back-pressure: class 0 must hold for five stalled cycles.
    do_sample("bp_s", 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b0);
    finalize = 1'b1;
    ready_in = 1'b0;
    tick;
    finalize = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_emit($sformatf("bp_hold%0d", i), 1'b0, 16'hA5A5, 2'd1);
      tick;
    end
    ready_in = 1'b1;
    #1;
    chk_emit("bp_release", 1'b0, 16'hA5A5, 2'd1);
    tick;
    chk_emit("bp_c1", 1'b1, 16'h0000, 2'd0);
    tick;
    chk("bp_clear_valid", 32'(valid_out), 32'd0);
    chk("bp_clear_ready", 32'(ready_out), 32'd0);
    tick;
    chk("bp_idle_ready", 32'(ready_out), 32'd1);
    do_finalize("bp_after", 16'h0000, 2'd0, 16'h0000, 2'd0, 1'b0);

    // Sample and finalize together: finalize wins, sample not consumed.
    do_finalize("simul", 16'h0000, 2'd0, 16'h0000, 2'd0, 1'b1);

    // Asynchronous reset during ACCUM chunk 2.
    do_sample("rst_a_pre", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    valid_in = 1'b1;
    hv1 = 16'hFFFF; hv2 = 16'hFFFF; hv3 = 16'hFFFF; label_in = 1'b0;
    tick;
    valid_in = 1'b0;
    chk("rst_a_busy", 32'(ready_out), 32'd0);
    tick;
    tick;
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_accum");
    #1 rst = 1'b0;
    tick;
    do_finalize("rst_a_after", 16'h0000, 2'd0, 16'h0000, 2'd0, 1'b0);

    // Asynchronous reset during EMIT.
    do_sample("rst_e_pre", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    finalize = 1'b1;
    ready_in = 1'b0;
    tick;
    finalize = 1'b0;
    chk_emit("rst_e_emit", 1'b0, 16'hFFFF, 2'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_emit");
    #1 rst = 1'b0;
    tick;
    do_finalize("rst_e_after", 16'h0000, 2'd0, 16'h0000, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
